mac_int_param: RTL and testbench

- Parametrised, handshaked signed integer MAC engine for the systolic-MAC datapath; successor to the fixed 16-bit single-accumulate FSM MAC.
- Accumulates a programmable-length dot product of signed A·B pairs into a guarded accumulator.
- Exposes valid/ready input flow control, a one-cycle done pulse, and sticky overflow reporting.
- Fed by the operand sequencer; y is consumed by the result collector when done is high.

---
 rtl/mac_int_param.sv | 170 +++++++++++++++++
 tb/tb_mac_int_param.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_int_param.sv
// mac_int_param: handshaked signed integer multiply-accumulate engine.
//
// Accumulates a programmable-length dot product of signed A*B pairs into a
// guarded ACC_W-bit accumulator. The multiply is registered (p_reg) and the add
// happens on the following edge, so beats may arrive back-to-back. A final DRAIN
// cycle folds the last product into y and raises a one-cycle done pulse.
//
// Optional feature, selected by the macro MAC_SAT_EN:
//   defined   - on overflow the accumulator clamps to the signed max/min value
//   undefined - the accumulator wraps modulo 2^ACC_W (no clamp logic is built)
// In both builds ovf is sticky from the overflowing add until the next accepted
// start.

module mac_int_param #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     valid,
  output logic                     ready,
  input  logic signed [DATA_W-1:0] A,
  input  logic signed [DATA_W-1:0] B,
  output logic signed [ACC_W-1:0]  y,
  output logic                     done,
  output logic                     busy,
  output logic                     ovf
);

  localparam int unsigned PW = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SatMax = {1'b0, {(ACC_W - 1) {1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {1'b1, {(ACC_W - 1) {1'b0}}};

  // The full product must fit in the accumulator without truncation.
  if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
    $error("mac_int_param: ACC_W must be >= 2*DATA_W");
  end

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain
  } state_e;

  state_e                   state;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         count;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PW-1:0]     p_reg;
  logic                     p_vld;

  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  p_ext;
  logic signed [ACC_W-1:0]  sum_raw;
  logic signed [ACC_W-1:0]  add_sum;
  logic                     add_ovf;
  logic                     accept;
  logic                     last_beat;

  // Full-width signed product and its sign extension to the accumulator width.
  always_comb begin
    prod  = PW'(A) * PW'(B);
    p_ext = ACC_W'(p_reg);
  end

  // Accumulator adder with two's-complement overflow detection; shared by the
  // pipelined add in ACCUM and the final fold in DRAIN.
  always_comb begin
    sum_raw = acc + p_ext;
    add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef MAC_SAT_EN
    // Clamp in the direction of the overflow: both operands share acc's sign.
    if (add_ovf) begin
      add_sum = acc[ACC_W-1] ? SatMin : SatMax;
    end else begin
      add_sum = sum_raw;
    end
`else
    add_sum = sum_raw;
`endif
  end

  // Handshake decode; ready is a registered copy of "in ACCUM".
  always_comb begin
    accept    = valid && ready;
    last_beat = (count == (len_q - LEN_W'(1)));
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= StIdle;
      len_q <= '0;
      count <= '0;
      acc   <= '0;
      p_reg <= '0;
      p_vld <= 1'b0;
      y     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            ovf <= 1'b0;
            if (len != '0) begin
              len_q <= len;
              acc   <= '0;
              count <= '0;
              p_vld <= 1'b0;
              ready <= 1'b1;
              busy  <= 1'b1;
              state <= StAccum;
            end else begin
              // Empty vector: report a zero result immediately.
              y    <= '0;
              done <= 1'b1;
            end
          end
        end

        StAccum: begin
          // Second pipeline stage: fold the product captured on the previous edge.
          if (p_vld) begin
            acc <= add_sum;
            if (add_ovf) begin
              ovf <= 1'b1;
            end
          end
          p_vld <= accept;
          if (accept) begin
            p_reg <= prod;
            count <= count + LEN_W'(1);
            if (last_beat) begin
              ready <= 1'b0;
              state <= StDrain;
            end
          end
        end

        StDrain: begin
          // The last product is still in p_reg; fold it straight into y.
          acc   <= add_sum;
          y     <= add_sum;
          if (add_ovf) begin
            ovf <= 1'b1;
          end
          p_vld <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_int_param.sv
// Testbench for mac_int_param (DATA_W=16, ACC_W=32, LEN_W=8).
// Expected results come from a sequential integer model of the dot product
// that applies the wrap/clamp rule after every add.

module tb_mac_int_param;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 8;
  localparam longint     AccMax = 64'sd2147483647;
  localparam longint     AccMin = -64'sd2147483648;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic [LW-1:0]        len = '0;
  logic                 valid = 1'b0;
  logic                 ready;
  logic signed [DW-1:0] A = '0;
  logic signed [DW-1:0] B = '0;
  logic signed [AW-1:0] y;
  logic                 done;
  logic                 busy;
  logic                 ovf;

  int errors = 0;
  int checks = 0;
  int a_q[$];
  int b_q[$];

  mac_int_param #(
    .DATA_W(DW),
    .ACC_W (AW),
    .LEN_W (LW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .len  (len),
    .valid(valid),
    .ready(ready),
    .A    (A),
    .B    (B),
    .y    (y),
    .done (done),
    .busy (busy),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sequential sum of products, each add wrapped or clamped to AW bits.
  task automatic model(output logic signed [AW-1:0] ym, output logic om);
    longint     acc;
    longint     s;
    logic [63:0] t;
    acc = 0;
    om  = 1'b0;
    for (int i = 0; i < a_q.size(); i++) begin
      s = acc + longint'(a_q[i]) * longint'(b_q[i]);
      if (s > AccMax || s < AccMin) begin
        om = 1'b1;
`ifdef MAC_SAT_EN
        s = (s > AccMax) ? AccMax : AccMin;
`else
        t = s;
        s = $signed(t[31:0]);
`endif
      end
      acc = s;
    end
    t  = acc;
    ym = t[31:0];
  endtask

  task automatic push_rand(input int n);
    logic signed [DW-1:0] r;
    a_q.delete();
    b_q.delete();
    for (int i = 0; i < n; i++) begin
      r = DW'($urandom);
      a_q.push_back(int'(r));
      r = DW'($urandom);
      b_q.push_back(int'(r));
    end
  endtask

  // Drives one operation from a_q/b_q and returns what was observed; returns in
  // the cycle where done is seen so a following call starts in the done cycle.
  task automatic run_op(input int gap, input bit mid_start, input bit extra,
                        output logic signed [AW-1:0] y_o, output logic ovf_o,
                        output int lat, output int dones, output bit rdy_after,
                        output bit tmo);
    int n;
    int w;
    n         = a_q.size();
    dones     = 0;
    tmo       = 1'b0;
    rdy_after = 1'b1;
    lat       = 0;
    y_o       = '0;
    ovf_o     = 1'b0;
    start     = 1'b1;
    len       = LW'(n);
    step();
    start = 1'b0;
    len   = LW'($urandom);
    if (done) dones++;
    for (int i = 0; i < n; i++) begin
      if (mid_start && i == 1) begin
        valid = 1'b0;
        start = 1'b1;
        len   = LW'(1);
        step();
        start = 1'b0;
        if (done) dones++;
      end
      for (int g = 0; g < gap; g++) begin
        valid = 1'b0;
        step();
        if (done) dones++;
      end
      valid = 1'b1;
      A     = DW'(a_q[i]);
      B     = DW'(b_q[i]);
      w     = 0;
      while (!ready && w < 50) begin
        step();
        w++;
        if (done) dones++;
      end
      if (w >= 50) begin
        tmo   = 1'b1;
        valid = 1'b0;
        return;
      end
      step();
      if (i == n - 1 && extra) begin
        A = DW'($urandom);
        B = DW'($urandom);
      end else begin
        valid = 1'b0;
      end
    end
    rdy_after = ready;
    lat       = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    valid = 1'b0;
    if (!done) tmo = 1'b1;
    else dones++;
    y_o   = y;
    ovf_o = ovf;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (y !== '0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic signed [AW-1:0] yo;
    logic o;
    int lat, dn;
    bit ra, tmo;
    a_q = '{30};
    b_q = '{40};
    run_op(0, 1'b0, 1'b0, yo, o, lat, dn, ra, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", tmo); end
    checks++; if (yo !== 32'sd1200) begin errors++; $display("FAIL single_y: got %0d expected 1200", yo); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", lat); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b expected 0", o); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_clear: got %b expected 0", done); end
    checks++; if (y !== 32'sd1200) begin errors++; $display("FAIL single_y_hold: got %0d expected 1200", y); end
  endtask

  task automatic test_gaps();
    logic signed [AW-1:0] yo;
    logic o;
    int lat, dn;
    bit ra, tmo;
    a_q = '{30, 10, 50, 100, 100};
    b_q = '{40, 16, 25, 23, 24};
    run_op(3, 1'b0, 1'b0, yo, o, lat, dn, ra, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL gaps_timeout: got %b expected 0", tmo); end
    checks++; if (yo !== 32'sd7310) begin errors++; $display("FAIL gaps_y: got %0d expected 7310", yo); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL gaps_done_count: got %0d expected 1", dn); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL gaps_ready_after: got %b expected 0", ra); end
  endtask

  task automatic test_back_to_back();
    logic signed [AW-1:0] yo, ym;
    logic o, om;
    int lat, dn;
    bit ra, tmo;
    a_q = '{-7, 12, -5};
    b_q = '{9, -4, -5};
    model(ym, om);
    run_op(0, 1'b0, 1'b1, yo, o, lat, dn, ra, tmo);
    checks++; if (yo !== ym) begin errors++; $display("FAIL b2b_y: got %0d expected %0d", yo, ym); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL b2b_ready_after: got %b expected 0", ra); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", lat); end
    // Next operation is started in the done cycle of the previous one.
    a_q = '{5};
    b_q = '{6};
    run_op(0, 1'b0, 1'b0, yo, o, lat, dn, ra, tmo);
    checks++; if (yo !== 32'sd30) begin errors++; $display("FAIL b2b_chain_y: got %0d expected 30", yo); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL b2b_chain_done_count: got %0d expected 1", dn); end
  endtask

  task automatic test_overflow();
    logic signed [AW-1:0] yo, ym;
    logic o, om;
    int lat, dn;
    bit ra, tmo;
    a_q = '{-32768, -32768};
    b_q = '{-32768, -32768};
    model(ym, om);
    run_op(1, 1'b0, 1'b0, yo, o, lat, dn, ra, tmo);
    checks++; if (yo !== ym) begin errors++; $display("FAIL ovf_y: got %0d expected %0d", yo, ym); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", o); end
    a_q = '{2};
    b_q = '{3};
    run_op(0, 1'b0, 1'b0, yo, o, lat, dn, ra, tmo);
    checks++; if (yo !== 32'sd6) begin errors++; $display("FAIL ovf_next_y: got %0d expected 6", yo); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL ovf_next_flag: got %b expected 0", o); end
  endtask

  task automatic test_len_zero();
    logic signed [AW-1:0] yo, ym;
    logic o, om;
    int lat, dn;
    bit ra, tmo;
    start = 1'b1;
    len   = '0;
    step();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b expected 1", done); end
    checks++; if (y !== '0) begin errors++; $display("FAIL len0_y: got %0d expected 0", y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b expected 0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_done_clear: got %b expected 0", done); end
    // A start pulse in the middle of ACCUM must neither restart nor shorten the op.
    a_q = '{11, -3, 7};
    b_q = '{13, 21, -9};
    model(ym, om);
    run_op(1, 1'b1, 1'b0, yo, o, lat, dn, ra, tmo);
    checks++; if (yo !== ym) begin errors++; $display("FAIL midstart_y: got %0d expected %0d", yo, ym); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL midstart_done_count: got %0d expected 1", dn); end
  endtask

  task automatic test_reset_mid();
    logic signed [AW-1:0] yo;
    logic o;
    int lat, dn;
    bit ra, tmo;
    start = 1'b1;
    len   = LW'(4);
    step();
    start = 1'b0;
    valid = 1'b1;
    A = 16'sd100;
    B = 16'sd100;
    step();
    A = 16'sd200;
    B = 16'sd3;
    step();
    valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (y !== '0) begin errors++; $display("FAIL rstmid_y: got %0d expected 0", y); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", ready); end
    #4 reset = 1'b1;
    step();
    a_q = '{3};
    b_q = '{3};
    run_op(0, 1'b0, 1'b0, yo, o, lat, dn, ra, tmo);
    checks++; if (yo !== 32'sd9) begin errors++; $display("FAIL rstmid_next_y: got %0d expected 9", yo); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL rstmid_done_count: got %0d expected 1", dn); end
  endtask

  task automatic test_random();
    logic signed [AW-1:0] yo, ym;
    logic o, om;
    int lat, dn;
    bit ra, tmo;
    for (int k = 0; k < 20; k++) begin
      push_rand(int'($urandom_range(1, 6)));
      model(ym, om);
      run_op(int'($urandom_range(0, 2)), 1'b0, $urandom_range(0, 1) == 1, yo, o, lat, dn, ra,
             tmo);
      checks++;
      if (tmo !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_timeout: got %b expected 0", k, tmo);
      end
      checks++;
      if (yo !== ym) begin
        errors++;
        $display("FAIL rand%0d_y: got %0d expected %0d", k, yo, ym);
      end
      checks++;
      if (o !== om) begin
        errors++;
        $display("FAIL rand%0d_ovf: got %b expected %b", k, o, om);
      end
      checks++;
      if (lat !== 2 || dn !== 1) begin
        errors++;
        $display("FAIL rand%0d_done: got latency %0d pulses %0d expected latency 2 pulses 1", k,
                 lat, dn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_back_to_back();
    test_overflow();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
